muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit, parametrised in WIDTH; sits in EX beside the ALU.
//  Accepts one operation per valid/ready handshake and runs radix-2 shift-add multiply or restoring divide.
//  Returns the result with an rd tag on a valid/ready output; the pipeline stalls on in_ready.
//  Supports a synchronous flush that cancels in-flight work (branch redirect / trap).
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4); iteration count = WIDTH
//  TAG_W  5   width of destination tag carried unchanged from input to output
// PORTS
//  clk        in   1      clock, rising edge
//  reset_n    in   1      asynchronous active-low reset
//  flush      in   1      synchronous cancel; highest priority
//  in_valid   in   1      operation request
//  in_ready   out  1      unit can accept (state IDLE and !flush)
//  funct3     in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a, b       in   WIDTH  rs1, rs2 operands
//  tag_in     in   TAG_W  destination register tag
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  operation result; stable while out_valid
//  tag_out    out  TAG_W  tag captured at accept
// BEHAVIOUR
//  Clock/reset: one clock clk; reset_n asynchronous, active-low. Asserting reset_n=0 mid-operation
//   aborts immediately.
//  Reset: state=IDLE; out_valid=0; result=0; tag_out=0; counter=0; internal accumulators=0.
//  States:
//   IDLE -> BUSY on accept (in_valid & in_ready), normal case.
//   IDLE -> DONE on accept for special cases.
//   BUSY: one iteration per edge, counter WIDTH-1 down to 0; at counter 0 -> FIX.
//   FIX: sign correction + result select, writes result/tag_out -> DONE.
//   DONE: out_valid=1; -> IDLE on out_ready. No accept while in DONE.
//  Latency (normal): accept edge E0; iterations E1..E_WIDTH; FIX at E_WIDTH+1;
//   out_valid high from E_WIDTH+1 (WIDTH+1 cycles after accept).
//  Special cases: at E0 -> DONE, out_valid the next cycle.
//   Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = a.
//   Signed overflow (a = 1<<(WIDTH-1), b = all ones): DIV = a; REM = 0.
//  Signedness:
//   MUL/MULH/DIV/REM: both operands signed. MULHSU: a signed, b unsigned.
//   MULHU/DIVU/REMU: both unsigned.
//   Magnitudes are taken at accept; the 2*WIDTH product is formed on magnitudes.
//  Result select: MUL = low WIDTH of product; MULH* = high WIDTH.
//   Product negated in FIX if operand signs differ.
//   Quotient negated if sign(a)^sign(b). Remainder takes sign of a.
//  Arithmetic: all internal adds/subtracts are WIDTH+1 bits; the counter is $clog2(WIDTH) bits;
//   no dependence on WIDTH=32.
//  Flush: any state -> IDLE on the next edge; out_valid drops; result is not written;
//   in_ready=0 during a flush cycle, so flush and in_valid in the same cycle accept nothing.
//  Operands and funct3 are sampled only at accept; later input changes are ignored.
//  result/tag_out change only at FIX or a special-case accept.
// TESTING
//  1. MUL a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; out_valid exactly 33 cycles after accept.
//  2. MULH, MULHSU, MULHU on a=b=0x80000000 -> 0x40000000, 0xC0000000, 0x40000000.
//  3. DIV -7/2 -> quotient 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIV x/0 -> 0xFFFFFFFF and REM x/0 -> x, both with 1-cycle latency.
//     DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  5. Hold out_ready=0 for 5 cycles in DONE -> result/tag_out/out_valid stable, in_ready=0;
//     then flush at iteration 10 of a new DIV -> IDLE next edge, no out_valid,
//     next op (MUL 3*4 -> 12) correct.
//  6. Deassert reset_n mid-BUSY (async) -> all outputs at reset values before the next edge;
//     WIDTH=8 rerun of cases 1-4 with truncated expected values.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the EX stage and muldiv_unit.
//  master (pipeline side): drives flush, in_valid, funct3, a, b, tag_in, out_ready;
//                          observes in_ready, out_valid, result, tag_out.
//  slave  (muldiv_unit):   the mirror image of master.
interface muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output flush, in_valid, funct3, a, b, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out
  );

  modport slave (
    input  flush, in_valid, funct3, a, b, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide), one bit per clock, WIDTH iterations per operation.
//  clk     : clock, rising edge
//  reset_n : asynchronous active-low reset
//  bus     : muldiv_unit_if.slave -- flush, in_valid/in_ready/funct3/a/b/tag_in request,
//            out_valid/out_ready/result/tag_out response
// Divide-by-zero and signed overflow are answered straight from the accept cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           reset_n,
  muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;         // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] mb_q, mb_d;         // magnitude of b
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready_s, accept_s;
  logic             a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [WIDTH:0]   a_mag_x_s, b_mag_x_s;
  logic             div_zero_s, ovf_s;
  logic [WIDTH-1:0] special_res_s;
  logic [WIDTH:0]   mul_sum_s, mul_sel_s, shifted_s, div_diff_s;
  logic             div_ge_s;
  logic [WIDTH:0]   lo_neg_s, hi_neg_s;
  logic             hi_cin_s;
  logic [WIDTH-1:0] lo_fix_s, hi_fix_s, fix_res_s;
  logic             unused_s;

  assign in_ready_s = (state_q == IDLE) & ~bus.flush;
  assign accept_s   = bus.in_valid & in_ready_s;

  // Operand decode at accept: signedness, magnitudes and the two short-circuit cases.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      3'b010:                         begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
      default:                        begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
    endcase
    a_neg_s   = a_sgn_s & bus.a[WIDTH-1];
    b_neg_s   = b_sgn_s & bus.b[WIDTH-1];
    a_mag_x_s = a_neg_s ? ({1'b0, ~bus.a} + ONE_X) : {1'b0, bus.a};
    b_mag_x_s = b_neg_s ? ({1'b0, ~bus.b} + ONE_X) : {1'b0, bus.b};
    div_zero_s = bus.funct3[2] & (bus.b == ZERO);
    ovf_s      = bus.funct3[2] & ~bus.funct3[0] & (bus.a == MIN_S) & (bus.b == ONES);
    if (div_zero_s) begin
      special_res_s = bus.funct3[1] ? bus.a : ONES;
    end else begin
      special_res_s = bus.funct3[1] ? ZERO : bus.a;
    end
  end

  // One iteration of multiply (add-then-shift) and restoring divide (shift-then-subtract).
  always_comb begin
    mul_sum_s  = {1'b0, acc_q} + {1'b0, mb_q};
    mul_sel_s  = lo_q[0] ? mul_sum_s : {1'b0, acc_q};
    shifted_s  = {acc_q, lo_q[WIDTH-1]};
    div_ge_s   = (shifted_s >= {1'b0, mb_q});
    div_diff_s = shifted_s - {1'b0, mb_q};
  end

  // Sign fix-up: the low half negation carries into the high half for products;
  // for division the high half (remainder) is negated on its own.
  always_comb begin
    lo_neg_s  = {1'b0, ~lo_q} + ONE_X;
    hi_cin_s  = op_q[2] ? 1'b1 : lo_neg_s[WIDTH];
    hi_neg_s  = {1'b0, ~acc_q} + {{WIDTH{1'b0}}, hi_cin_s};
    lo_fix_s  = neg_q ? lo_neg_s[WIDTH-1:0] : lo_q;
    hi_fix_s  = neg_q ? hi_neg_s[WIDTH-1:0] : acc_q;
    case (op_q)
      3'b000, 3'b100, 3'b101:         fix_res_s = lo_fix_s;
      3'b001, 3'b010, 3'b011,
      3'b110, 3'b111:                 fix_res_s = hi_fix_s;
      default:                        fix_res_s = lo_fix_s;
    endcase
  end

  // Carry-outs that are provably zero or not needed.
  assign unused_s = ^{a_mag_x_s[WIDTH], b_mag_x_s[WIDTH], div_diff_s[WIDTH], hi_neg_s[WIDTH]};

  // Next-state logic for the controller and datapath; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    mb_d        = mb_q;
    result_d    = result_q;
    tag_d       = tag_q;
    tag_out_d   = tag_out_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_d  = bus.funct3;
            tag_d = bus.tag_in;
            if (div_zero_s | ovf_s) begin
              result_d    = special_res_s;
              tag_out_d   = bus.tag_in;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end else begin
              acc_d   = ZERO;
              lo_d    = a_mag_x_s[WIDTH-1:0];
              mb_d    = b_mag_x_s[WIDTH-1:0];
              neg_d   = (bus.funct3[2] & bus.funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = BUSY;
            end
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (op_q[2]) begin
            acc_d = div_ge_s ? div_diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], div_ge_s};
          end else begin
            acc_d = mul_sel_s[WIDTH:1];
            lo_d  = {mul_sel_s[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          result_d    = fix_res_s;
          tag_out_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      op_q        <= 3'b000;
      neg_q       <= 1'b0;
      acc_q       <= ZERO;
      lo_q        <= ZERO;
      mb_q        <= ZERO;
      result_q    <= ZERO;
      tag_q       <= {TAG_W{1'b0}};
      tag_out_q   <= {TAG_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      mb_q        <= mb_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      tag_out_q   <= tag_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.tag_out   = tag_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Each accepted request pushes its expected result, tag and latency (edges from the
// accept edge until out_valid is seen) into a per-instance queue; a monitor per
// instance compares whenever out_valid is presented and pops on the handshake.
module tb_muldiv_unit;
  localparam int TW = 5;

  typedef struct {
    logic [63:0]   res;
    logic [TW-1:0] tag;
    int            acc;
    int            lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic hold0  = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if #(.WIDTH(32), .TAG_W(TW)) b32 ();
  muldiv_unit_if #(.WIDTH(8),  .TAG_W(TW)) b8 ();

  muldiv_unit #(.WIDTH(32), .TAG_W(TW)) dut32 (.clk(clk), .reset_n(rst_n), .bus(b32.slave));
  muldiv_unit #(.WIDTH(8),  .TAG_W(TW)) dut8  (.clk(clk), .reset_n(rst_n), .bus(b8.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain signed/unsigned arithmetic on wide integers, RISC-V M rules.
  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] ai,
                                            input logic [63:0] bi, input int w);
    logic [63:0] m, a, b;
    logic signed [127:0] sa, sb, r;
    logic a_sig, b_sig;
    m = mask_of(w);
    a = ai & m;
    b = bi & m;
    a_sig = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    b_sig = (f == 3'd0) || (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    sa = {64'd0, a};
    sb = {64'd0, b};
    if (a_sig && a[w-1]) sa = sa - (128'sd1 <<< w);
    if (b_sig && b[w-1]) sb = sb - (128'sd1 <<< w);
    case (f)
      3'd0:             begin r = sa * sb; return r[63:0] & m; end
      3'd1, 3'd2, 3'd3: begin r = sa * sb; r = r >>> w; return r[63:0] & m; end
      3'd4, 3'd5:       begin if (b == 64'd0) return m; r = sa / sb; return r[63:0] & m; end
      default:          begin if (b == 64'd0) return a; r = sa % sb; return r[63:0] & m; end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [63:0] ai,
                                input logic [63:0] bi, input int w);
    logic [63:0] m, a, b;
    m = mask_of(w);
    a = ai & m;
    b = bi & m;
    if (f[2] && (b == 64'd0 || (!f[0] && a == (64'd1 << (w - 1)) && b == m))) return 0;
    return w + 1;
  endfunction

  function automatic logic ov(input int sel);
    return (sel == 0) ? b32.out_valid : b8.out_valid;
  endfunction
  function automatic logic ir(input int sel);
    return (sel == 0) ? b32.in_ready : b8.in_ready;
  endfunction
  function automatic logic [63:0] res(input int sel);
    return (sel == 0) ? {32'd0, b32.result} : {56'd0, b8.result};
  endfunction
  function automatic logic [TW-1:0] tg(input int sel);
    return (sel == 0) ? b32.tag_out : b8.tag_out;
  endfunction
  function automatic int qn(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic drv(input int sel, input logic v, input logic [2:0] f,
                     input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] t);
    if (sel == 0) begin
      b32.in_valid = v; b32.funct3 = f; b32.a = a[31:0]; b32.b = b[31:0]; b32.tag_in = t;
    end else begin
      b8.in_valid = v; b8.funct3 = f; b8.a = a[7:0]; b8.b = b[7:0]; b8.tag_in = t;
    end
  endtask

  task automatic mon(input int sel);
    logic seen;
    logic rdy;
    logic [63:0] last_r;
    logic [TW-1:0] last_t;
    exp_t e;
    seen = 1'b0;
    last_r = 64'd0;
    last_t = '0;
    forever begin
      @(negedge clk);
      rdy = 1'b0;
      if (rst_n && ov(sel)) begin
        if (!seen) begin
          if (qn(sel) == 0) begin
            chk("unexpected_out_valid", {63'd0, ov(sel)}, 64'd0);
          end else begin
            e = (sel == 0) ? q0[0] : q1[0];
            chk("result", res(sel), e.res);
            chk("tag_out", {59'd0, tg(sel)}, {59'd0, e.tag});
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            seen = 1'b1;
            last_r = res(sel);
            last_t = tg(sel);
          end
        end else begin
          chk("result_stable", res(sel), last_r);
          chk("tag_stable", {59'd0, tg(sel)}, {59'd0, last_t});
        end
        rdy = (sel == 0 && hold0) ? 1'b0 : 1'($urandom_range(0, 1));
        if (rdy && seen) begin
          if (sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          seen = 1'b0;
        end
      end else begin
        seen = 1'b0;
      end
      if (sel == 0) b32.out_ready = rdy; else b8.out_ready = rdy;
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic issue(input int sel, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [TW-1:0] t);
    int w;
    int n;
    exp_t e;
    w = (sel == 0) ? 32 : 8;
    @(negedge clk);
    drv(sel, 1'b1, f, a, b, t);
    n = 0;
    while (!ir(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", {63'd0, ir(sel)}, 64'd1);
    end else begin
      e.res = ref_model(f, a, b, w);
      e.tag = t;
      e.acc = cyc + 1;
      e.lat = lat_of(f, a, b, w);
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    // scramble the request lines: the unit must have captured them at accept
    drv(sel, 1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, TW'($urandom));
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (qn(sel) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (qn(sel) != 0) chk("drain_timeout", 64'(qn(sel)), 64'd0);
  endtask

  task automatic run_directed(input int sel);
    int w;
    logic [63:0] m, top, x;
    w   = (sel == 0) ? 32 : 8;
    m   = mask_of(w);
    top = 64'd1 << (w - 1);
    x   = 64'h0000_1234_5678_9abc & m;
    issue(sel, 3'd0, 64'd7, m - 64'd2, 5'd1);   // MUL 7 * -3
    issue(sel, 3'd1, top, top, 5'd2);            // MULH
    issue(sel, 3'd2, top, top, 5'd3);            // MULHSU
    issue(sel, 3'd3, top, top, 5'd4);            // MULHU
    issue(sel, 3'd4, m - 64'd6, 64'd2, 5'd5);    // DIV -7 / 2
    issue(sel, 3'd6, m - 64'd6, 64'd2, 5'd6);    // REM -7 , 2
    issue(sel, 3'd5, 64'd100, 64'd7, 5'd7);      // DIVU
    issue(sel, 3'd7, 64'd100, 64'd7, 5'd8);      // REMU
    issue(sel, 3'd4, x, 64'd0, 5'd9);            // DIV by zero
    issue(sel, 3'd6, x, 64'd0, 5'd10);           // REM by zero
    issue(sel, 3'd5, x, 64'd0, 5'd11);           // DIVU by zero
    issue(sel, 3'd4, top, m, 5'd12);             // DIV overflow
    issue(sel, 3'd6, top, m, 5'd13);             // REM overflow
    drain(sel);
  endtask

  task automatic run_random(input int sel, input int n_ops);
    int w;
    logic [63:0] m, a, b;
    int k;
    w = (sel == 0) ? 32 : 8;
    m = mask_of(w);
    for (int i = 0; i < n_ops; i++) begin
      a = {$urandom, $urandom} & m;
      b = {$urandom, $urandom} & m;
      k = $urandom_range(0, 9);
      if (k == 0) b = 64'd0;
      if (k == 1) begin a = 64'd1 << (w - 1); b = m; end
      if (k == 2) b = 64'($urandom_range(1, 5));
      issue(sel, 3'($urandom), a, b, TW'($urandom));
    end
    drain(sel);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    b32.flush = 1'b0; b8.flush = 1'b0;
    b32.out_ready = 1'b0; b8.out_ready = 1'b0;
    drv(0, 1'b0, 3'd0, 64'd0, 64'd0, '0);
    drv(1, 1'b0, 3'd0, 64'd0, 64'd0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {63'd0, b32.out_valid}, 64'd0);
    chk("reset_result", res(0), 64'd0);
    chk("reset_tag_out", {59'd0, b32.tag_out}, 64'd0);
    chk("reset_in_ready", {63'd0, b32.in_ready}, 64'd1);
    chk("reset_result_w8", res(1), 64'd0);
    rst_n = 1'b1;

    run_directed(0);
    run_random(0, 60);

    // Held response: outputs stay put and nothing new is accepted.
    hold0 = 1'b1;
    issue(0, 3'd0, 64'd11, 64'd13, 5'd21);
    for (int n = 0; n < 100 && !b32.out_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'd0, b32.out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, b32.in_ready}, 64'd0);
    end
    hold0 = 1'b0;
    drain(0);

    // Flush a divide around iteration 10.
    issue(0, 3'd4, 64'd1000, 64'd3, 5'd22);
    repeat (10) @(posedge clk);
    @(negedge clk);
    b32.flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, b32.in_ready}, 64'd0);
    void'(q0.pop_back());
    @(posedge clk);
    #1;
    b32.flush = 1'b0;
    @(negedge clk);
    chk("post_flush_idle", {63'd0, b32.in_ready}, 64'd1);
    chk("post_flush_out_valid", {63'd0, b32.out_valid}, 64'd0);
    // flush together with a request: nothing is taken
    b32.flush = 1'b1;
    drv(0, 1'b1, 3'd0, 64'd5, 64'd6, 5'd23);
    #1;
    chk("flush_req_in_ready", {63'd0, b32.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    b32.flush = 1'b0;
    drv(0, 1'b0, 3'd0, 64'd0, 64'd0, '0);
    repeat (40) @(negedge clk);
    issue(0, 3'd0, 64'd3, 64'd4, 5'd24);
    drain(0);

    // Asynchronous reset in the middle of an operation.
    issue(0, 3'd4, 64'd77777, 64'd3, 5'd25);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'd0, b32.out_valid}, 64'd0);
    chk("async_rst_result", res(0), 64'd0);
    chk("async_rst_tag_out", {59'd0, b32.tag_out}, 64'd0);
    chk("async_rst_in_ready", {63'd0, b32.in_ready}, 64'd1);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    run_directed(1);
    run_random(1, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
